// File: rtl/nbit_serial_twos_com_if.sv
// Valid/ready bundle for the bit-serial two's-complement negator.
// The master drives operands and takes results; the slave is the negator.
interface nbit_serial_twos_com_if #(
    parameter int unsigned Width = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] A;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] Com;
    logic             ovf;

    modport master (
        output in_valid, A, out_ready,
        input  in_ready, out_valid, Com, ovf
    );

    modport slave (
        input  in_valid, A, out_ready,
        output in_ready, out_valid, Com, ovf
    );
endinterface

// File: rtl/nbit_serial_twos_com.sv
// Bit-serial negator: Com = -A mod 2^Width, processed LSB first.
// Bits are copied up to and including the first 1, and every later bit is inverted.
module nbit_serial_twos_com #(
    parameter int unsigned Width = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nbit_serial_twos_com_if.slave    bus
);
    localparam int unsigned CntW = $clog2(Width);
    localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [Width-1:0]  sh_q, sh_d;
    logic [Width-1:0]  res_q, res_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              seen_one_q, seen_one_d;
    logic              ovf_r_q, ovf_r_d;
    logic [Width-1:0]  com_q, com_d;
    logic              ovf_q, ovf_d;
    logic              obit;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            seen_one_q <= 1'b0;
            ovf_r_q    <= 1'b0;
            com_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            seen_one_q <= seen_one_d;
            ovf_r_q    <= ovf_r_d;
            com_q      <= com_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state and serial datapath
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        seen_one_d = seen_one_q;
        ovf_r_d    = ovf_r_q;
        com_d      = com_q;
        ovf_d      = ovf_q;
        obit       = seen_one_q ? ~sh_q[0] : sh_q[0];

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sh_d       = bus.A;
                    res_d      = '0;
                    cnt_d      = '0;
                    seen_one_d = 1'b0;
                    ovf_r_d    = (bus.A == MinNeg);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                seen_one_d = seen_one_q | sh_q[0];
                sh_d       = sh_q >> 1;
                res_d      = {obit, res_q[Width-1:1]};
                cnt_d      = cnt_q + CntW'(1);
                if (cnt_q == CntW'(Width - 1)) begin
                    // Last bit: publish the full result and stop the counter
                    com_d   = {obit, res_q[Width-1:1]};
                    ovf_d   = ovf_r_q;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Com       = com_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nbit_serial_twos_com.sv
// Directed and random checks of the serial negator at Width 5, 2 and 8
// against an arithmetic reference (-A mod 2^Width).
module tb_nbit_serial_twos_com;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    nbit_serial_twos_com_if #(.Width(5)) if5 ();
    nbit_serial_twos_com_if #(.Width(2)) if2 ();
    nbit_serial_twos_com_if #(.Width(8)) if8 ();

    nbit_serial_twos_com #(.Width(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
    nbit_serial_twos_com #(.Width(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    nbit_serial_twos_com #(.Width(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_com(input int unsigned a, input int unsigned w);
        int unsigned m;
        m = 32'd1 << w;
        return (m - (a % m)) % m;
    endfunction

    function automatic logic ref_ovf(input int unsigned a, input int unsigned w);
        return a == (32'd1 << (w - 1));
    endfunction

    // One complete Width=5 transaction with out_ready held high
    task automatic op5(input int unsigned a, input string tag);
        int n;
        int lat;
        if5.in_valid = 1'b1;
        if5.A        = 5'(a);
        n = 0;
        while (!if5.in_ready && n < 50) begin tick(); n++; end
        tick();
        if5.in_valid = 1'b0;
        lat = 0;
        while (!if5.out_valid && lat < 50) begin tick(); lat++; end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_com"}, 32'(if5.Com), ref_com(a, 5));
        check({tag, "_ovf"}, 32'(if5.ovf), 32'(ref_ovf(a, 5)));
        tick();
    endtask

    task automatic op2(input int unsigned a);
        int n;
        if2.in_valid = 1'b1;
        if2.A        = 2'(a);
        n = 0;
        while (!if2.in_ready && n < 50) begin tick(); n++; end
        tick();
        if2.in_valid = 1'b0;
        n = 0;
        while (!if2.out_valid && n < 50) begin tick(); n++; end
        check("w2_valid", 32'(if2.out_valid), 32'd1);
        check("w2_com", 32'(if2.Com), ref_com(a, 2));
        check("w2_ovf", 32'(if2.ovf), 32'(ref_ovf(a, 2)));
        tick();
    endtask

    task automatic op8(input int unsigned a);
        int n;
        if8.in_valid = 1'b1;
        if8.A        = 8'(a);
        n = 0;
        while (!if8.in_ready && n < 50) begin tick(); n++; end
        tick();
        if8.in_valid = 1'b0;
        n = 0;
        while (!if8.out_valid && n < 50) begin tick(); n++; end
        check("w8_valid", 32'(if8.out_valid), 32'd1);
        check("w8_com", 32'(if8.Com), ref_com(a, 8));
        check("w8_ovf", 32'(if8.ovf), 32'(ref_ovf(a, 8)));
        tick();
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        if5.in_valid = 1'b0; if5.A = '0; if5.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.A = '0; if2.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.A = '0; if8.out_ready = 1'b1;

        // Reset values
        #1;
        check("rst_valid", 32'(if5.out_valid), 32'd0);
        check("rst_com", 32'(if5.Com), 32'd0);
        check("rst_ovf", 32'(if5.ovf), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(if5.in_ready), 32'd1);

        // Exhaustive Width=5 sweep
        for (int a = 0; a < 32; a++) op5(32'(a), "sweep");

        // Directed operands
        op5(32'd6, "a6");
        op5(32'd1, "a1");
        op5(32'd0, "a0");

        // Random operands
        for (int i = 0; i < 12; i++) op5($urandom_range(31, 0), "rand5");

        // Backpressure: result and handshake frozen while out_ready is low
        if5.out_ready = 1'b0;
        if5.in_valid  = 1'b1;
        if5.A         = 5'd3;
        tick();
        if5.in_valid = 1'b0;
        n = 0;
        while (!if5.out_valid && n < 50) begin tick(); n++; end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(if5.out_valid), 32'd1);
            check("bp_com", 32'(if5.Com), 32'h1d);
            check("bp_ready", 32'(if5.in_ready), 32'd0);
            tick();
        end
        if5.out_ready = 1'b1;
        tick();
        check("bp_ready_after", 32'(if5.in_ready), 32'd1);
        check("bp_valid_after", 32'(if5.out_valid), 32'd0);

        // Busy input: second operand held until the block returns to IDLE
        if5.in_valid = 1'b1;
        if5.A        = 5'd7;
        tick();
        if5.A = 5'd9;
        check("busy_ready", 32'(if5.in_ready), 32'd0);
        n = 0;
        while (!if5.out_valid && n < 50) begin tick(); n++; end
        check("busy_com7", 32'(if5.Com), 32'h19);
        tick();
        check("busy_idle_ready", 32'(if5.in_ready), 32'd1);
        tick();
        if5.in_valid = 1'b0;
        n = 0;
        while (!if5.out_valid && n < 50) begin tick(); n++; end
        check("busy_lat9", 32'(n), 32'd5);
        check("busy_com9", 32'(if5.Com), 32'h17);
        tick();

        // Asynchronous reset in the middle of SHIFT
        if5.in_valid = 1'b1;
        if5.A        = 5'd12;
        tick();
        if5.in_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(if5.out_valid), 32'd0);
        check("mid_rst_com", 32'(if5.Com), 32'd0);
        check("mid_rst_ovf", 32'(if5.ovf), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_ready", 32'(if5.in_ready), 32'd1);
        op5(32'd1, "post_rst");

        // Width=2 full sweep
        for (int a = 0; a < 4; a++) op2(32'(a));

        // Width=8 corners and random operands
        op8(32'h00);
        op8(32'h80);
        op8(32'hff);
        op8(32'h01);
        for (int i = 0; i < 16; i++) op8($urandom_range(255, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
